// File: rtl/pe_pkg.sv
// Shared definitions for the PE command driver: opcodes, field widths,
// phase encodings and the job descriptor.
package pe_pkg;

  localparam int P_W = 5;
  localparam int Q_W = 3;
  localparam int S_W = 4;

  localparam logic [2:0] CMD_SET   = 3'b000;
  localparam logic [2:0] CMD_LD_IF = 3'b001;
  localparam logic [2:0] CMD_LD_W  = 3'b010;
  localparam logic [2:0] CMD_CONV  = 3'b011;
  localparam logic [2:0] CMD_ACC   = 3'b100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_LD_IF = 3'd2;
  localparam logic [2:0] ST_LD_W  = 3'd3;
  localparam logic [2:0] ST_CONV  = 3'd4;
  localparam logic [2:0] ST_ACC   = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic [Q_W-1:0] q;
    logic [S_W-1:0] s;
    logic           skip_wght;
    logic           skip_acc;
  } desc_t;

  // Rounded-up word count for four 8-bit lanes per word.
  function automatic logic [11:0] ceil_div4(input logic [11:0] x);
    logic [11:0] t;
    t = x + 12'd3;
    return {2'b00, t[11:2]};
  endfunction

  function automatic logic phase_has_op(input logic [2:0] st);
    logic r;
    case (st)
      ST_SET, ST_LD_IF, ST_LD_W, ST_CONV, ST_ACC: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] phase_opcode(input logic [2:0] st);
    logic [2:0] r;
    case (st)
      ST_SET:   r = CMD_SET;
      ST_LD_IF: r = CMD_LD_IF;
      ST_LD_W:  r = CMD_LD_W;
      ST_CONV:  r = CMD_CONV;
      ST_ACC:   r = CMD_ACC;
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pe_stream_gate.sv
// Zero-latency valid/ready pass-through that admits exactly i_n beats while
// enabled, then closes; the beat counter restarts whenever i_clr is high.
module pe_stream_gate #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [CNT_W-1:0]  i_n,
  input  logic [DWIDTH-1:0] i_src_data,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  output logic [DWIDTH-1:0] o_dst_data,
  output logic              o_dst_valid,
  input  logic              i_dst_ready,
  output logic              o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_active;
  logic             w_beat;

  always_comb begin
    w_active    = i_en & (r_cnt != i_n);
    o_dst_valid = i_src_valid & w_active;
    o_src_ready = i_dst_ready & w_active;
    o_dst_data  = i_src_data;
    w_beat      = i_src_valid & i_dst_ready & w_active;
    o_done      = (r_cnt == i_n);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_beat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pe_cmd_driver.sv
// Host-side PE driver: sequences SET/LOAD_IFMAP/LOAD_WGHT/CONV/ACC opcodes and
// gates the ifmap, weight, psum-in and psum-drain streams with exact word counts.
module pe_cmd_driver
  import pe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [4:0]        i_layer_p,
  input  logic [2:0]        i_layer_q,
  input  logic [3:0]        i_layer_s,
  input  logic              i_skip_wght,
  input  logic              i_skip_acc,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_pe_opcode,
  output logic              o_pe_opcode_valid,
  input  logic              i_pe_opcode_ready,
  input  logic [DWIDTH-1:0] i_ifmap_src_data,
  input  logic              i_ifmap_src_valid,
  output logic              o_ifmap_src_ready,
  output logic [DWIDTH-1:0] o_pe_ifmap_data,
  output logic              o_pe_ifmap_valid,
  input  logic              i_pe_ifmap_ready,
  input  logic [DWIDTH-1:0] i_wght_src_data,
  input  logic              i_wght_src_valid,
  output logic              o_wght_src_ready,
  output logic [DWIDTH-1:0] o_pe_wght_data,
  output logic              o_pe_wght_valid,
  input  logic              i_pe_wght_ready,
  input  logic [DWIDTH-1:0] i_psum_src_data,
  input  logic              i_psum_src_valid,
  output logic              o_psum_src_ready,
  output logic [DWIDTH-1:0] o_pe_psum_data,
  output logic              o_pe_psum_valid,
  input  logic              i_pe_psum_ready,
  input  logic [DWIDTH-1:0] i_pe_psum_out_data,
  input  logic              i_pe_psum_out_valid,
  output logic              o_pe_psum_out_ready,
  output logic [DWIDTH-1:0] o_sink_data,
  output logic              o_sink_valid,
  input  logic              i_sink_ready
);

  logic [2:0]       r_state;
  desc_t            r_desc;
  logic             r_op_valid;
  logic [2:0]       r_opcode;
  logic             r_issued;
  logic             r_decode;
  logic             r_busy;
  logic             r_done;

  logic [11:0]      w_pqs;
  logic [CNT_W-1:0] w_n_if;
  logic [CNT_W-1:0] w_n_w;
  logic [CNT_W-1:0] w_n_ps;
  logic             w_has_if;
  logic             w_has_w;
  logic             w_has_acc;
  logic             w_op_fire;
  logic             w_wait_ok;
  logic             w_go;
  logic [2:0]       w_nxt;
  logic             w_if_done;
  logic             w_w_done;
  logic             w_ps_done;
  logic             w_dr_done;

  // Word counts derive from the latched descriptor, so they stay fixed for the whole job.
  always_comb begin
    w_pqs     = 12'(r_desc.p) * 12'(r_desc.q) * 12'(r_desc.s);
    w_n_if    = CNT_W'(r_desc.q) * CNT_W'(r_desc.s);
    w_n_w     = CNT_W'(ceil_div4(w_pqs));
    w_n_ps    = CNT_W'(ceil_div4(12'(r_desc.p)));
    w_has_if  = (w_n_if != {CNT_W{1'b0}});
    w_has_w   = ~r_desc.skip_wght & (w_n_w != {CNT_W{1'b0}});
    w_has_acc = ~r_desc.skip_acc & (w_n_ps != {CNT_W{1'b0}});
  end

  // The cycle right after an opcode accept is the PE decode cycle; its ready is not trusted.
  always_comb begin
    w_op_fire = r_op_valid & i_pe_opcode_ready;
    w_wait_ok = r_issued & ~r_decode & i_pe_opcode_ready;
    w_go      = 1'b0;
    w_nxt     = r_state;
    case (r_state)
      ST_IDLE: begin
        w_go  = i_start;
        w_nxt = ST_SET;
      end
      ST_SET: begin
        w_go  = w_wait_ok;
        w_nxt = w_has_if ? ST_LD_IF : (w_has_w ? ST_LD_W : ST_CONV);
      end
      ST_LD_IF: begin
        w_go  = w_wait_ok & w_if_done;
        w_nxt = w_has_w ? ST_LD_W : ST_CONV;
      end
      ST_LD_W: begin
        w_go  = w_wait_ok & w_w_done;
        w_nxt = ST_CONV;
      end
      ST_CONV: begin
        w_go  = w_wait_ok;
        w_nxt = w_has_acc ? ST_ACC : ST_DONE;
      end
      ST_ACC: begin
        w_go  = w_wait_ok & w_ps_done;
        w_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_go  = w_dr_done;
        w_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_go  = 1'b1;
        w_nxt = ST_IDLE;
      end
      default: begin
        w_go  = 1'b1;
        w_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_op_valid <= 1'b0;
      r_opcode   <= 3'b000;
      r_issued   <= 1'b0;
      r_decode   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_desc     <= '0;
    end else begin
      if (w_go) begin
        r_state    <= w_nxt;
        r_op_valid <= phase_has_op(w_nxt);
        r_opcode   <= phase_opcode(w_nxt);
        r_issued   <= ~phase_has_op(w_nxt);
        r_decode   <= 1'b0;
        r_done     <= (w_nxt == ST_DONE);
        r_busy     <= (w_nxt != ST_IDLE);
      end else begin
        r_state    <= r_state;
        r_op_valid <= r_op_valid & ~w_op_fire;
        r_opcode   <= r_opcode;
        r_issued   <= r_issued | w_op_fire;
        r_decode   <= w_op_fire;
        r_done     <= 1'b0;
        r_busy     <= r_busy;
      end
      if ((r_state == ST_IDLE) && i_start) begin
        r_desc.p         <= i_layer_p;
        r_desc.q         <= i_layer_q;
        r_desc.s         <= i_layer_s;
        r_desc.skip_wght <= i_skip_wght;
        r_desc.skip_acc  <= i_skip_acc;
      end else begin
        r_desc <= r_desc;
      end
    end
  end

  always_comb begin
    o_busy            = r_busy;
    o_done            = r_done;
    o_pe_opcode       = r_opcode;
    o_pe_opcode_valid = r_op_valid;
  end

  pe_stream_gate #(.DWIDTH(DWIDTH), .CNT_W(CNT_W)) u_gate_if (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == ST_LD_IF) & r_issued), .i_clr(r_state != ST_LD_IF), .i_n(w_n_if),
    .i_src_data(i_ifmap_src_data), .i_src_valid(i_ifmap_src_valid), .o_src_ready(o_ifmap_src_ready),
    .o_dst_data(o_pe_ifmap_data), .o_dst_valid(o_pe_ifmap_valid), .i_dst_ready(i_pe_ifmap_ready),
    .o_done(w_if_done)
  );

  pe_stream_gate #(.DWIDTH(DWIDTH), .CNT_W(CNT_W)) u_gate_w (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == ST_LD_W) & r_issued), .i_clr(r_state != ST_LD_W), .i_n(w_n_w),
    .i_src_data(i_wght_src_data), .i_src_valid(i_wght_src_valid), .o_src_ready(o_wght_src_ready),
    .o_dst_data(o_pe_wght_data), .o_dst_valid(o_pe_wght_valid), .i_dst_ready(i_pe_wght_ready),
    .o_done(w_w_done)
  );

  pe_stream_gate #(.DWIDTH(DWIDTH), .CNT_W(CNT_W)) u_gate_ps (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == ST_ACC) & r_issued), .i_clr(r_state != ST_ACC), .i_n(w_n_ps),
    .i_src_data(i_psum_src_data), .i_src_valid(i_psum_src_valid), .o_src_ready(o_psum_src_ready),
    .o_dst_data(o_pe_psum_data), .o_dst_valid(o_pe_psum_valid), .i_dst_ready(i_pe_psum_ready),
    .o_done(w_ps_done)
  );

  // The drain has no opcode of its own; it opens as soon as DRAIN is entered.
  pe_stream_gate #(.DWIDTH(DWIDTH), .CNT_W(CNT_W)) u_gate_dr (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en(r_state == ST_DRAIN), .i_clr(r_state != ST_DRAIN), .i_n(w_n_ps),
    .i_src_data(i_pe_psum_out_data), .i_src_valid(i_pe_psum_out_valid), .o_src_ready(o_pe_psum_out_ready),
    .o_dst_data(o_sink_data), .o_dst_valid(o_sink_valid), .i_dst_ready(i_sink_ready),
    .o_done(w_dr_done)
  );

endmodule
